dso_cmd_ctrl_n: RTL
===================

// Module: dso_cmd_ctrl_n
// PURPOSE
//  Parametrised command processor for the DSO digital core, sitting between the UART/cmd receiver and the SPI master.
//  Decodes 24-bit host commands: configures per-channel AFE gain pots and the trigger pot, and reads/writes the calibration EEPROM.
//  Dumps a channel trace with EEPROM offset/gain correction applied; supports 1-4 channels and any trace depth.
//  Every response is sent only after its SPI transaction completes; unknown opcode or out-of-range channel returns a NAK.
// PARAMETERS
//  NUM_CH   4    number of capture channels, 1..4
//  DEPTH    512  trace RAM entries per channel, >=2, any value (need not be 2^n)
//  ADDR_W   $clog2(DEPTH)  trace address width (derived)
//  EEP_SS   3'd6 slave select of calibration EEPROM
// PORTS
//  clk        in  1       system clock
//  rst        in  1       asynchronous active-high reset
//  cmd        in  24      [19:16] opcode, [12:10] gain ggg, [9:8] channel, [13:8] EEP addr, [7:0] data/length
//  cmd_rdy    in  1       cmd valid; held until clr_cmd_rdy
//  clr_cmd_rdy out 1      1-cycle pulse: cmd accepted
//  SPI_data   out 16      SPI word, valid when wrt_SPI pulses
//  ss         out 3       slave select, stable from wrt_SPI until SPI_done
//  wrt_SPI    out 1       1-cycle start of SPI transaction
//  SPI_done   in  1       1-cycle pulse: transaction complete
//  EEP_data   in  8       EEPROM byte returned by the previous read transaction
//  send_resp  out 1       1-cycle pulse: resp_data valid
//  resp_data  out 8       response byte, held until the next send_resp
//  resp_sent  in  1       1-cycle pulse: response transmitted
//  trace_end  in  ADDR_W  address of newest sample (from capture unit)
//  ch_sel     out 2       trace RAM channel select
//  addr       out ADDR_W  trace RAM read address; rdata valid 1 cycle later
//  rdata      in  8       trace RAM read data of ch_sel
// BEHAVIOUR
//  Reset values: all outputs 0 except resp_data=8'hA5; state IDLE; gain regs 3'b000; cal off/gain 8'h00.
//  Opcodes: 1 DUMP, 2 CFG_GAIN, 3 SET_TRIG, 8 WRT_EEP, 9 RD_EEP; any other -> NAK.
//  IDLE: on cmd_rdy, pulse clr_cmd_rdy the same cycle, latch cmd internally; the next cmd is not sampled before returning to IDLE.
//  Channel check (DUMP, CFG_GAIN): cmd[9:8]>=NUM_CH -> resp 8'hEE, no SPI activity.
//  CFG_GAIN: ss=3'd1+ch; SPI_data={8'h13,G}; G by ggg = 02,05,09,14,28,46,6B,DD.
//   On SPI_done: store ggg in gain[ch], send 8'hA5.
//  SET_TRIG: ss=0, SPI_data={8'h13,cmd[7:0]}; on SPI_done send 8'hA5.
//  WRT_EEP: ss=EEP_SS, SPI_data={2'b01,cmd[13:0]}; on SPI_done send 8'hA5.
//  RD_EEP: txn1 {2'b00,cmd[13:8],8'h00}, then dummy txn2 16'h0000; on 2nd SPI_done send EEP_data.
//  DUMP sequence, all on EEP_SS:
//   - txn A {2'b00,ch,gain[ch],1'b0,8'h00} (offset address)
//   - txn B {...,1'b1,8'h00} (gain address); on B done latch off=EEP_data
//   - txn C 16'h0000; on C done latch cgain=EEP_data
//   - addr=(trace_end==DEPTH-1)?0:trace_end+1 (oldest sample)
//  Dump length N = cmd[7:0]==0 ? DEPTH : min(cmd[7:0],DEPTH); no ACK byte, only N samples.
//  Per sample: addr drive -> next cycle register corrected into resp_data, pulse send_resp -> wait resp_sent.
//   Then addr = (addr==DEPTH-1) ? 0 : addr+1; after N-th resp_sent -> IDLE.
//  Correction: d = raw - off as 10-bit signed (off two's complement); p = d*cgain (unsigned Q1.7).
//   corrected = clamp(p>>>7, 0, 255). Saturate, never wrap.
//  Any response: send_resp 1 cycle, then wait resp_sent before next state; ignore SPI_done when no txn is outstanding.
//  States: IDLE, SPI_WAIT, EEP_RD2, CAL_A, CAL_B, CAL_C, D_ADDR, D_CALC, D_WAIT, RESP_WAIT.
//  rst mid-operation: immediate return to reset values; outstanding SPI/response abandoned.
// TESTING
//  T1 CFG_GAIN cmd=24'h020C00 (ch0,g=3) -> ss=1, SPI_data=16'h1314; after SPI_done resp A5.
//   Later DUMP reads EEP addr {00,011,0}.
//  T2 cmd=24'h020300 with NUM_CH=3 -> clr_cmd_rdy, resp EE, no wrt_SPI; cmd=24'h070000 -> EE.
//  T3 RD_EEP cmd=24'h092A00 -> SPI 16'h2A00 then 16'h0000; EEP_data=8'h5C at 2nd done -> resp 5C.
//  T4 DEPTH=300, trace_end=299, DUMP len=3 -> addr 0,1,2; off=8'h10,cgain=8'h80, raw 20,05,FF -> 10,00,EF.
//  T5 cgain=8'hFF,off=8'hF0(-16), raw=8'hF0 -> 8'hFF saturated.
//   len=0 DEPTH=512 trace_end=10 -> 512 bytes, addr 11..511,0..10.
//  T6 assert rst during D_WAIT -> outputs at reset values next cycle; new CFG_GAIN executes normally.

Source files
------------

// File: rtl/dso_cmd_ctrl_n_if.sv
// Host-command, SPI, response and trace-RAM signals of the DSO command processor.
// The master modport is the command processor side.
interface dso_cmd_ctrl_n_if #(
    parameter int ADDR_W = 9
);
    logic [23:0]       cmd;
    logic              cmd_rdy;
    logic              clr_cmd_rdy;
    logic [15:0]       SPI_data;
    logic [2:0]        ss;
    logic              wrt_SPI;
    logic              SPI_done;
    logic [7:0]        EEP_data;
    logic              send_resp;
    logic [7:0]        resp_data;
    logic              resp_sent;
    logic [ADDR_W-1:0] trace_end;
    logic [1:0]        ch_sel;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        rdata;

    modport master (
        input  cmd, cmd_rdy, SPI_done, EEP_data, resp_sent, trace_end, rdata,
        output clr_cmd_rdy, SPI_data, ss, wrt_SPI, send_resp, resp_data, ch_sel, addr
    );

    modport slave (
        output cmd, cmd_rdy, SPI_done, EEP_data, resp_sent, trace_end, rdata,
        input  clr_cmd_rdy, SPI_data, ss, wrt_SPI, send_resp, resp_data, ch_sel, addr
    );
endinterface

// File: rtl/dso_cmd_ctrl_n.sv
// DSO command processor: decodes host commands into AFE pot / EEPROM SPI transactions
// and streams calibrated channel traces back to the host.
module dso_cmd_ctrl_n #(
    parameter int         NUM_CH = 4,
    parameter int         DEPTH  = 512,
    parameter int         ADDR_W = $clog2(DEPTH),
    parameter logic [2:0] EEP_SS = 3'd6
) (
    input logic              clk,
    input logic              rst,
    dso_cmd_ctrl_n_if.master bus
);
    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] SPI_WAIT  = 4'd1;
    localparam logic [3:0] EEP_RD2   = 4'd2;
    localparam logic [3:0] CAL_A     = 4'd3;
    localparam logic [3:0] CAL_B     = 4'd4;
    localparam logic [3:0] CAL_C     = 4'd5;
    localparam logic [3:0] D_ADDR    = 4'd6;
    localparam logic [3:0] D_CALC    = 4'd7;
    localparam logic [3:0] D_WAIT    = 4'd8;
    localparam logic [3:0] RESP_WAIT = 4'd9;

    localparam logic [3:0] OP_DUMP = 4'd1;
    localparam logic [3:0] OP_GAIN = 4'd2;
    localparam logic [3:0] OP_TRIG = 4'd3;
    localparam logic [3:0] OP_WEEP = 4'd8;
    localparam logic [3:0] OP_REEP = 4'd9;

    localparam int                CNT_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [3:0]        state;
    logic [19:0]       cmd_q;
    logic [2:0]        gain [4];
    logic [7:0]        off;
    logic [7:0]        cgain;
    logic [CNT_W-1:0]  remain;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        ch_sel_q;
    logic [15:0]       spi_q;
    logic [2:0]        ss_q;
    logic              wrt_q;
    logic              send_q;
    logic [7:0]        resp_q;

    logic [3:0]        op_in;
    logic [1:0]        ch_in;
    logic              ch_bad;
    logic [7:0]        gval;
    logic [CNT_W-1:0]  dump_len;
    logic [ADDR_W-1:0] oldest;
    logic [ADDR_W-1:0] next_addr;
    logic signed [9:0]  diff;
    logic signed [18:0] prod;
    logic signed [11:0] scaled;
    logic [7:0]         corr;

    assign bus.clr_cmd_rdy = (state == IDLE) && bus.cmd_rdy && !rst;
    assign bus.SPI_data    = spi_q;
    assign bus.ss          = ss_q;
    assign bus.wrt_SPI     = wrt_q;
    assign bus.send_resp   = send_q;
    assign bus.resp_data   = resp_q;
    assign bus.ch_sel      = ch_sel_q;
    assign bus.addr        = addr_q;

    always_comb begin
        op_in  = bus.cmd[19:16];
        ch_in  = bus.cmd[9:8];
        ch_bad = ({30'b0, ch_in} >= 32'(NUM_CH));
        case (bus.cmd[12:10])
            3'd0:    gval = 8'h02;
            3'd1:    gval = 8'h05;
            3'd2:    gval = 8'h09;
            3'd3:    gval = 8'h14;
            3'd4:    gval = 8'h28;
            3'd5:    gval = 8'h46;
            3'd6:    gval = 8'h6B;
            default: gval = 8'hDD;
        endcase
        if (cmd_q[7:0] == 8'h00 || {24'b0, cmd_q[7:0]} >= 32'(DEPTH))
            dump_len = CNT_W'(DEPTH);
        else
            dump_len = CNT_W'(cmd_q[7:0]);
        oldest    = (bus.trace_end == LAST_ADDR) ? '0 : bus.trace_end + ADDR_W'(1);
        next_addr = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    end

    // Offset is two's complement, gain is unsigned Q1.7; clamp instead of wrapping.
    always_comb begin
        diff   = $signed({2'b00, bus.rdata}) - $signed({{2{off[7]}}, off});
        prod   = diff * $signed({1'b0, cgain});
        scaled = 12'(prod >>> 7);
        if (scaled < 12'sd0)
            corr = '0;
        else if (scaled > 12'sd255)
            corr = '1;
        else
            corr = scaled[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cmd_q    <= '0;
            off      <= '0;
            cgain    <= '0;
            remain   <= '0;
            addr_q   <= '0;
            ch_sel_q <= '0;
            spi_q    <= '0;
            ss_q     <= '0;
            wrt_q    <= 1'b0;
            send_q   <= 1'b0;
            resp_q   <= 8'hA5;
            for (int unsigned i = 0; i < 4; i++)
                gain[i] <= '0;
        end else begin
            wrt_q  <= 1'b0;
            send_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_rdy) begin
                        cmd_q <= bus.cmd[19:0];
                        case (op_in)
                            OP_DUMP: begin
                                if (ch_bad) begin
                                    resp_q <= 8'hEE;
                                    send_q <= 1'b1;
                                    state  <= RESP_WAIT;
                                end else begin
                                    ch_sel_q <= ch_in;
                                    ss_q     <= EEP_SS;
                                    spi_q    <= {2'b00, ch_in, gain[ch_in], 1'b0, 8'h00};
                                    wrt_q    <= 1'b1;
                                    state    <= CAL_A;
                                end
                            end
                            OP_GAIN: begin
                                if (ch_bad) begin
                                    resp_q <= 8'hEE;
                                    send_q <= 1'b1;
                                    state  <= RESP_WAIT;
                                end else begin
                                    ss_q  <= 3'd1 + {1'b0, ch_in};
                                    spi_q <= {8'h13, gval};
                                    wrt_q <= 1'b1;
                                    state <= SPI_WAIT;
                                end
                            end
                            OP_TRIG: begin
                                ss_q  <= 3'd0;
                                spi_q <= {8'h13, bus.cmd[7:0]};
                                wrt_q <= 1'b1;
                                state <= SPI_WAIT;
                            end
                            OP_WEEP: begin
                                ss_q  <= EEP_SS;
                                spi_q <= {2'b01, bus.cmd[13:0]};
                                wrt_q <= 1'b1;
                                state <= SPI_WAIT;
                            end
                            OP_REEP: begin
                                ss_q  <= EEP_SS;
                                spi_q <= {2'b00, bus.cmd[13:8], 8'h00};
                                wrt_q <= 1'b1;
                                state <= SPI_WAIT;
                            end
                            default: begin
                                resp_q <= 8'hEE;
                                send_q <= 1'b1;
                                state  <= RESP_WAIT;
                            end
                        endcase
                    end
                end
                SPI_WAIT: begin
                    if (bus.SPI_done) begin
                        if (cmd_q[19:16] == OP_REEP) begin
                            spi_q <= '0;
                            wrt_q <= 1'b1;
                            state <= EEP_RD2;
                        end else begin
                            if (cmd_q[19:16] == OP_GAIN)
                                gain[cmd_q[9:8]] <= cmd_q[12:10];
                            resp_q <= 8'hA5;
                            send_q <= 1'b1;
                            state  <= RESP_WAIT;
                        end
                    end
                end
                EEP_RD2: begin
                    if (bus.SPI_done) begin
                        resp_q <= bus.EEP_data;
                        send_q <= 1'b1;
                        state  <= RESP_WAIT;
                    end
                end
                // EEP_data always reflects the read issued one transaction earlier.
                CAL_A: begin
                    if (bus.SPI_done) begin
                        spi_q <= {spi_q[15:9], 1'b1, 8'h00};
                        wrt_q <= 1'b1;
                        state <= CAL_B;
                    end
                end
                CAL_B: begin
                    if (bus.SPI_done) begin
                        off   <= bus.EEP_data;
                        spi_q <= '0;
                        wrt_q <= 1'b1;
                        state <= CAL_C;
                    end
                end
                CAL_C: begin
                    if (bus.SPI_done) begin
                        cgain  <= bus.EEP_data;
                        addr_q <= oldest;
                        remain <= dump_len;
                        state  <= D_ADDR;
                    end
                end
                D_ADDR: state <= D_CALC;
                D_CALC: begin
                    resp_q <= corr;
                    send_q <= 1'b1;
                    state  <= D_WAIT;
                end
                D_WAIT: begin
                    if (bus.resp_sent) begin
                        if (remain == CNT_W'(1)) begin
                            state <= IDLE;
                        end else begin
                            remain <= remain - CNT_W'(1);
                            addr_q <= next_addr;
                            state  <= D_ADDR;
                        end
                    end
                end
                RESP_WAIT: begin
                    if (bus.resp_sent)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
